// File: rtl/stg_wb_commit.sv
// stg_wb_commit: EX writeback/commit stage, one pipeline register feeding the GP/AR/SR files.
// Latency: a beat captured at edge N is on the bypass after N and in the files after N+1.
// Backpressure: iw_stall freezes capture, commit and the retire counter; iw_flush drops only the incoming beat.
// Ports: iw_clk, iw_rst (sync, active high); iw_valid/iw_stall/iw_flush beat control;
//        iw_tgt_{gp,ar,sr}[_we] + iw_{,ar_,sr_}result write-backs; iw_rd_* read indices;
//        ow_*_val bypassed read data, ow_flags committed FL[3:0], ow_retired, ow_pending.
module stg_wb_commit #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 48,
   parameter int GP_N   = 16,
   parameter int AR_N   = 4,
   parameter int SR_N   = 4
) (
   input  logic                      iw_clk,
   input  logic                      iw_rst,
   input  logic                      iw_valid,
   input  logic [$clog2(GP_N)-1:0]   iw_tgt_gp,
   input  logic                      iw_tgt_gp_we,
   input  logic [DATA_W-1:0]         iw_result,
   input  logic [$clog2(AR_N)-1:0]   iw_tgt_ar,
   input  logic                      iw_tgt_ar_we,
   input  logic [ADDR_W-1:0]         iw_ar_result,
   input  logic [$clog2(SR_N)-1:0]   iw_tgt_sr,
   input  logic                      iw_tgt_sr_we,
   input  logic [ADDR_W-1:0]         iw_sr_result,
   input  logic                      iw_stall,
   input  logic                      iw_flush,
   input  logic [$clog2(GP_N)-1:0]   iw_rd_gp_a,
   input  logic [$clog2(GP_N)-1:0]   iw_rd_gp_b,
   input  logic [$clog2(AR_N)-1:0]   iw_rd_ar,
   input  logic [$clog2(SR_N)-1:0]   iw_rd_sr,
   output logic [DATA_W-1:0]         ow_gp_a_val,
   output logic [DATA_W-1:0]         ow_gp_b_val,
   output logic [ADDR_W-1:0]         ow_ar_val,
   output logic [ADDR_W-1:0]         ow_sr_val,
   output logic [3:0]                ow_flags,
   output logic [ADDR_W-1:0]         ow_retired,
   output logic                      ow_pending
);

   localparam int GP_IW  = $clog2(GP_N);
   localparam int AR_IW  = $clog2(AR_N);
   localparam int SR_IW  = $clog2(SR_N);
   localparam int FL_IDX = 2;

   typedef struct packed {
      logic              gp_we;
      logic [GP_IW-1:0]  gp_idx;
      logic [DATA_W-1:0] gp_dat;
      logic              ar_we;
      logic [AR_IW-1:0]  ar_idx;
      logic [ADDR_W-1:0] ar_dat;
      logic              sr_we;
      logic [SR_IW-1:0]  sr_idx;
      logic [ADDR_W-1:0] sr_dat;
   } beat_t;

   logic [DATA_W-1:0] gp_q [GP_N];
   logic [DATA_W-1:0] gp_d [GP_N];
   logic [ADDR_W-1:0] ar_q [AR_N];
   logic [ADDR_W-1:0] ar_d [AR_N];
   logic [ADDR_W-1:0] sr_q [SR_N];
   logic [ADDR_W-1:0] sr_d [SR_N];
   beat_t             beat_q, beat_d;
   logic              pending_q, pending_d;
   logic [ADDR_W-1:0] retired_q, retired_d;
   logic              capture;

   assign capture = iw_valid && !iw_flush;

   always_comb begin
      gp_d      = gp_q;
      ar_d      = ar_q;
      sr_d      = sr_q;
      beat_d    = beat_q;
      pending_d = pending_q;
      retired_d = retired_q;
      if (!iw_stall) begin
         // Commit the older beat and capture the new one in the same edge.
         if (pending_q) begin
            if (beat_q.gp_we) gp_d[beat_q.gp_idx] = beat_q.gp_dat;
            if (beat_q.ar_we) ar_d[beat_q.ar_idx] = beat_q.ar_dat;
            if (beat_q.sr_we) sr_d[beat_q.sr_idx] = beat_q.sr_dat;
            retired_d = retired_q + ADDR_W'(1);
         end
         pending_d = capture;
         if (capture) begin
            beat_d.gp_we  = iw_tgt_gp_we;
            beat_d.gp_idx = iw_tgt_gp;
            beat_d.gp_dat = iw_result;
            beat_d.ar_we  = iw_tgt_ar_we;
            beat_d.ar_idx = iw_tgt_ar;
            beat_d.ar_dat = iw_ar_result;
            beat_d.sr_we  = iw_tgt_sr_we;
            beat_d.sr_idx = iw_tgt_sr;
            beat_d.sr_dat = iw_sr_result;
         end
      end
   end

   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         for (int i = 0; i < GP_N; i++) gp_q[i] <= '0;
         for (int i = 0; i < AR_N; i++) ar_q[i] <= '0;
         for (int i = 0; i < SR_N; i++) sr_q[i] <= '0;
         beat_q    <= '0;
         pending_q <= 1'b0;
         retired_q <= '0;
      end else begin
         gp_q      <= gp_d;
         ar_q      <= ar_d;
         sr_q      <= sr_d;
         beat_q    <= beat_d;
         pending_q <= pending_d;
         retired_q <= retired_d;
      end
   end

   // Bypass only from the registered beat; the iw_* write inputs never reach the read ports.
   assign ow_gp_a_val = (pending_q && beat_q.gp_we && beat_q.gp_idx == iw_rd_gp_a)
                        ? beat_q.gp_dat : gp_q[iw_rd_gp_a];
   assign ow_gp_b_val = (pending_q && beat_q.gp_we && beat_q.gp_idx == iw_rd_gp_b)
                        ? beat_q.gp_dat : gp_q[iw_rd_gp_b];
   assign ow_ar_val   = (pending_q && beat_q.ar_we && beat_q.ar_idx == iw_rd_ar)
                        ? beat_q.ar_dat : ar_q[iw_rd_ar];
   assign ow_sr_val   = (pending_q && beat_q.sr_we && beat_q.sr_idx == iw_rd_sr)
                        ? beat_q.sr_dat : sr_q[iw_rd_sr];

   // Flags come from the committed file only, so they lag the SR bypass by one edge.
   assign ow_flags    = sr_q[FL_IDX][3:0];
   assign ow_retired  = retired_q;
   assign ow_pending  = pending_q;

endmodule

// File: tb/tb_stg_wb_commit.sv
module tb_stg_wb_commit;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid, stall, flush;
   logic [3:0]  tgt_gp;
   logic        gp_we;
   logic [23:0] result;
   logic [1:0]  tgt_ar;
   logic        ar_we;
   logic [47:0] ar_result;
   logic [1:0]  tgt_sr;
   logic        sr_we;
   logic [47:0] sr_result;
   logic [3:0]  rd_a, rd_b;
   logic [1:0]  rd_ar, rd_sr;
   logic [23:0] gp_a_val, gp_b_val;
   logic [47:0] ar_val, sr_val, retired;
   logic [3:0]  flags;
   logic        pending;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   stg_wb_commit dut (
      .iw_clk(clk), .iw_rst(rst), .iw_valid(valid),
      .iw_tgt_gp(tgt_gp), .iw_tgt_gp_we(gp_we), .iw_result(result),
      .iw_tgt_ar(tgt_ar), .iw_tgt_ar_we(ar_we), .iw_ar_result(ar_result),
      .iw_tgt_sr(tgt_sr), .iw_tgt_sr_we(sr_we), .iw_sr_result(sr_result),
      .iw_stall(stall), .iw_flush(flush),
      .iw_rd_gp_a(rd_a), .iw_rd_gp_b(rd_b), .iw_rd_ar(rd_ar), .iw_rd_sr(rd_sr),
      .ow_gp_a_val(gp_a_val), .ow_gp_b_val(gp_b_val), .ow_ar_val(ar_val),
      .ow_sr_val(sr_val), .ow_flags(flags), .ow_retired(retired), .ow_pending(pending)
   );

   typedef struct {
      logic        valid, stall, flush;
      logic        gp_we;
      logic [3:0]  gp_idx;
      logic [23:0] gp_dat;
      logic        sr_we;
      logic [1:0]  sr_idx;
      logic [47:0] sr_dat;
      logic [3:0]  rd_a, rd_b;
      logic [1:0]  rd_sr;
      logic [23:0] exp_a, exp_b;
      logic [47:0] exp_sr;
      logic [3:0]  exp_flags;
      logic [47:0] exp_ret;
      logic        exp_pend;
   } vec_t;

   vec_t vecs [21];
   vec_t sb_q [$];

   function automatic vec_t mk(
      input logic va, st, fl, gwe, input logic [3:0] gi, input logic [23:0] gd,
      input logic swe, input logic [1:0] si, input logic [47:0] sd,
      input logic [3:0] ra, rb, input logic [1:0] rs,
      input logic [23:0] ea, eb, input logic [47:0] es, input logic [3:0] ef,
      input logic [47:0] er, input logic ep);
      vec_t v;
      v.valid = va; v.stall = st; v.flush = fl;
      v.gp_we = gwe; v.gp_idx = gi; v.gp_dat = gd;
      v.sr_we = swe; v.sr_idx = si; v.sr_dat = sd;
      v.rd_a = ra; v.rd_b = rb; v.rd_sr = rs;
      v.exp_a = ea; v.exp_b = eb; v.exp_sr = es; v.exp_flags = ef;
      v.exp_ret = er; v.exp_pend = ep;
      return v;
   endfunction

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      valid = 0; stall = 0; flush = 0;
      tgt_gp = 0; gp_we = 0; result = 0;
      tgt_ar = 0; ar_we = 0; ar_result = 0;
      tgt_sr = 0; sr_we = 0; sr_result = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t e;
      rst = 1; idle_inputs();
      rd_a = 0; rd_b = 0; rd_ar = 0; rd_sr = 0;

      //            va st fl gwe gi  gd         swe si sd     ra  rb  rs  exp_a      exp_b      exp_sr ef    ret pend
      vecs[0]  = mk(1, 0, 0, 1, 3, 24'h123456, 0, 0, 48'h0, 3,  0,  0, 24'h123456, 24'h0,     48'h0, 4'h0, 0, 1);
      vecs[1]  = mk(0, 0, 0, 0, 0, 24'h0,      0, 0, 48'h0, 3,  0,  0, 24'h123456, 24'h0,     48'h0, 4'h0, 1, 0);
      vecs[2]  = mk(1, 0, 0, 0, 0, 24'h0,      1, 2, 48'h5, 3,  0,  2, 24'h123456, 24'h0,     48'h5, 4'h0, 1, 1);
      vecs[3]  = mk(0, 0, 0, 0, 0, 24'h0,      0, 0, 48'h0, 3,  0,  2, 24'h123456, 24'h0,     48'h5, 4'h5, 2, 0);
      vecs[4]  = mk(1, 0, 0, 0, 0, 24'h0,      1, 2, 48'h0, 3,  0,  2, 24'h123456, 24'h0,     48'h0, 4'h5, 2, 1);
      vecs[5]  = mk(0, 0, 0, 0, 0, 24'h0,      0, 0, 48'h0, 3,  0,  2, 24'h123456, 24'h0,     48'h0, 4'h0, 3, 0);
      vecs[6]  = mk(1, 0, 0, 1, 5, 24'hABCDEF, 0, 0, 48'h0, 5,  3,  0, 24'hABCDEF, 24'h123456, 48'h0, 4'h0, 3, 1);
      vecs[7]  = mk(0, 1, 0, 0, 0, 24'h0,      0, 0, 48'h0, 5,  3,  0, 24'hABCDEF, 24'h123456, 48'h0, 4'h0, 3, 1);
      vecs[8]  = mk(1, 1, 0, 1, 5, 24'h111111, 0, 0, 48'h0, 5,  3,  0, 24'hABCDEF, 24'h123456, 48'h0, 4'h0, 3, 1);
      vecs[9]  = mk(1, 1, 1, 1, 3, 24'h222222, 0, 0, 48'h0, 5,  3,  0, 24'hABCDEF, 24'h123456, 48'h0, 4'h0, 3, 1);
      vecs[10] = mk(0, 0, 0, 0, 0, 24'h0,      0, 0, 48'h0, 5,  3,  0, 24'hABCDEF, 24'h123456, 48'h0, 4'h0, 4, 0);
      vecs[11] = mk(0, 0, 0, 0, 0, 24'h0,      0, 0, 48'h0, 5,  3,  0, 24'hABCDEF, 24'h123456, 48'h0, 4'h0, 4, 0);
      vecs[12] = mk(1, 0, 0, 1, 2, 24'h000011, 0, 0, 48'h0, 2,  1,  0, 24'h000011, 24'h0,     48'h0, 4'h0, 4, 1);
      vecs[13] = mk(1, 0, 1, 1, 1, 24'hFFFFFF, 0, 0, 48'h0, 2,  1,  0, 24'h000011, 24'h0,     48'h0, 4'h0, 5, 0);
      vecs[14] = mk(0, 0, 0, 0, 0, 24'h0,      0, 0, 48'h0, 2,  1,  0, 24'h000011, 24'h0,     48'h0, 4'h0, 5, 0);
      vecs[15] = mk(1, 0, 0, 1, 4, 24'h000001, 0, 0, 48'h0, 4,  4,  0, 24'h000001, 24'h000001, 48'h0, 4'h0, 5, 1);
      vecs[16] = mk(1, 0, 0, 1, 4, 24'h000002, 0, 0, 48'h0, 4,  4,  0, 24'h000002, 24'h000002, 48'h0, 4'h0, 6, 1);
      vecs[17] = mk(1, 0, 0, 1, 4, 24'h000003, 0, 0, 48'h0, 4,  4,  0, 24'h000003, 24'h000003, 48'h0, 4'h0, 7, 1);
      vecs[18] = mk(0, 0, 0, 0, 0, 24'h0,      0, 0, 48'h0, 4,  3,  0, 24'h000003, 24'h123456, 48'h0, 4'h0, 8, 0);
      vecs[19] = mk(1, 0, 0, 0, 4, 24'h00FFFF, 0, 0, 48'h0, 4,  3,  0, 24'h000003, 24'h123456, 48'h0, 4'h0, 8, 1);
      vecs[20] = mk(0, 0, 0, 0, 0, 24'h0,      0, 0, 48'h0, 4,  3,  0, 24'h000003, 24'h123456, 48'h0, 4'h0, 9, 0);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 0;
      rd_a = 3; rd_sr = 2;
      #1;
      chk("rst_gp_a", {24'h0, gp_a_val}, 48'h0);
      chk("rst_sr", sr_val, 48'h0);
      chk("rst_flags", {44'h0, flags}, 48'h0);
      chk("rst_retired", retired, 48'h0);
      chk("rst_pending", {47'h0, pending}, 48'h0);

      // Table-driven vectors through the scoreboard
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         valid = vecs[i].valid; stall = vecs[i].stall; flush = vecs[i].flush;
         gp_we = vecs[i].gp_we; tgt_gp = vecs[i].gp_idx; result = vecs[i].gp_dat;
         sr_we = vecs[i].sr_we; tgt_sr = vecs[i].sr_idx; sr_result = vecs[i].sr_dat;
         rd_a = vecs[i].rd_a; rd_b = vecs[i].rd_b; rd_sr = vecs[i].rd_sr; rd_ar = 0;
         sb_q.push_back(vecs[i]);
         @(posedge clk); #1;
         if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_empty: got 0 entries expected 1");
         end else begin
            e = sb_q.pop_front();
            chk($sformatf("v%0d_gp_a", i), {24'h0, gp_a_val}, {24'h0, e.exp_a});
            chk($sformatf("v%0d_gp_b", i), {24'h0, gp_b_val}, {24'h0, e.exp_b});
            chk($sformatf("v%0d_sr", i), sr_val, e.exp_sr);
            chk($sformatf("v%0d_flags", i), {44'h0, flags}, {44'h0, e.exp_flags});
            chk($sformatf("v%0d_retired", i), retired, e.exp_ret);
            chk($sformatf("v%0d_pending", i), {47'h0, pending}, {47'h0, e.exp_pend});
         end
      end

      // Simultaneous GP/AR/SR write; no combinational bypass from the inputs
      @(negedge clk);
      idle_inputs();
      valid = 1;
      gp_we = 1; tgt_gp = 7; result = 24'hAAAAAA;
      ar_we = 1; tgt_ar = 1; ar_result = 48'h1234_5678_9ABC;
      sr_we = 1; tgt_sr = 3; sr_result = 48'hFEDC_BA98_7654;
      rd_a = 7; rd_ar = 1; rd_sr = 3;
      #1;
      chk("nobyp_gp", {24'h0, gp_a_val}, 48'h0);
      chk("nobyp_ar", ar_val, 48'h0);
      @(posedge clk); #1;
      chk("multi_byp_gp", {24'h0, gp_a_val}, 48'hAAAAAA);
      chk("multi_byp_ar", ar_val, 48'h1234_5678_9ABC);
      chk("multi_byp_sr", sr_val, 48'hFEDC_BA98_7654);
      @(negedge clk); idle_inputs();
      @(posedge clk); #1;
      chk("multi_file_gp", {24'h0, gp_a_val}, 48'hAAAAAA);
      chk("multi_file_ar", ar_val, 48'h1234_5678_9ABC);
      chk("multi_file_sr", sr_val, 48'hFEDC_BA98_7654);
      chk("multi_retired", retired, 48'd10);
      chk("multi_pending", {47'h0, pending}, 48'h0);

      // Pending beat without GP enable must not shadow the file entry
      @(negedge clk);
      valid = 1; tgt_gp = 7; result = 24'h555555; gp_we = 0;
      @(posedge clk); #1;
      chk("nowe_gp_file", {24'h0, gp_a_val}, 48'hAAAAAA);
      chk("nowe_pending", {47'h0, pending}, 48'h1);

      // Mid-run reset clears everything, including the pending beat
      @(negedge clk);
      idle_inputs(); rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("rst2_gp", {24'h0, gp_a_val}, 48'h0);
      chk("rst2_ar", ar_val, 48'h0);
      chk("rst2_sr", sr_val, 48'h0);
      chk("rst2_retired", retired, 48'h0);
      chk("rst2_pending", {47'h0, pending}, 48'h0);
      @(posedge clk); #1;
      chk("rst2_hold_retired", retired, 48'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
